// File: rtl/axis_frame_receiver_pkg.sv
// rtl/axis_frame_receiver_pkg.sv - shared types and constants for the frame receiver
//
// Contents:
//   state_t       receiver FSM states (IDLE, RECV, DRAIN)
//   fifo_entry_t  default {addr, data} skid FIFO entry
//   ERR_*         bit positions inside the sticky error vector
package axis_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 12;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

  localparam int ERR_EOL_EARLY   = 0;
  localparam int ERR_EOL_MISSING = 1;
  localparam int ERR_EOF         = 2;
  localparam int ERR_W           = 3;

endpackage

// File: rtl/axis_frame_receiver_if.sv
// rtl/axis_frame_receiver_if.sv - pixel stream bundle between upscaler and receiver
//
// Signals:
//   s_axis_tdata   pixel word
//   s_axis_tvalid  pixel valid
//   s_axis_tready  sink ready (driven by the slave)
//   i_eol / i_eof  end-of-line / end-of-frame sideband, qualified by tvalid
interface axis_frame_receiver_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              i_eol;
  logic              i_eof;

  modport master (
    output s_axis_tdata, s_axis_tvalid, i_eol, i_eof,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, i_eol, i_eof,
    output s_axis_tready
  );
endinterface

// File: rtl/axis_frame_receiver_skid.sv
// rtl/axis_frame_receiver_skid.sv - 2-entry skid FIFO between stream and write port
//
// Ports:
//   i_clk, i_rstn  clock, synchronous active-low reset (flushes contents)
//   i_push, i_din  write side; a push while full is ignored
//   i_pop          read side; a pop while empty is ignored
//   o_dout         head entry
//   o_cnt          occupancy 0..2
//   o_empty        occupancy is zero
module axis_skid_fifo2 import axis_rx_pkg::*; #(
  parameter type entry_t = fifo_entry_t
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_push,
  input  entry_t     i_din,
  input  logic       i_pop,
  output entry_t     o_dout,
  output logic [1:0] o_cnt,
  output logic       o_empty
);
  entry_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_cnt;
  logic       w_push;
  logic       w_pop;

  assign w_push  = i_push & (r_cnt != 2'd2);
  assign w_pop   = i_pop & (r_cnt != 2'd0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_cnt   = r_cnt;
  assign o_empty = (r_cnt == 2'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/axis_frame_receiver.sv
// rtl/axis_frame_receiver.sv - stream sink: geometry check, linear frame-buffer writes
//
// Ports:
//   i_clk, i_rstn      clock, synchronous active-low reset
//   i_en               receive enable (gates tready only)
//   s_axis             pixel stream with eol/eof sideband (slave side)
//   o_wr_en/addr/data  frame-buffer write request, addr = y*H_OUT+x
//   i_wr_ready         write accepted when o_wr_en & i_wr_ready
//   o_busy             frame in progress
//   o_frame_done       one-cycle pulse once the last pixel has been written
//   o_frame_cnt        completed frames (wraps)
//   o_err_*            sticky framing errors, cleared by i_clr_err
module axis_frame_receiver import axis_rx_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int H_OUT  = 64,
  parameter int V_OUT  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  axis_frame_receiver_if.slave s_axis,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_cnt,
  output logic              o_err_eol_early,
  output logic              o_err_eol_missing,
  output logic              o_err_eof,
  input  logic              i_clr_err
);
  localparam int X_W = $clog2(H_OUT + 1);
  localparam int Y_W = $clog2(V_OUT + 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_OUT - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_OUT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_OUT);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            r_state, w_next_state;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_base;
  logic              r_drop;
  logic [ERR_W-1:0]  r_err, w_err_set;
  logic [15:0]       r_frame_cnt;
  logic [1:0]        w_fifo_cnt;
  logic              w_fifo_empty, w_accept, w_push, w_pop, w_eol, w_eof;
  entry_t            w_push_entry, w_head;

  assign w_eol = s_axis.i_eol;
  assign w_eof = s_axis.i_eof;

  // Ready never looks at tvalid, so the upstream can't form a combinational loop.
  assign s_axis.s_axis_tready = i_en & (w_fifo_cnt < 2'd2) & (r_state != DRAIN);
  assign w_accept = s_axis.s_axis_tvalid & s_axis.s_axis_tready;
  // While resyncing after a missing eol, pixels are consumed but not written.
  assign w_push   = w_accept & ~r_drop;
  assign w_pop    = ~w_fifo_empty & i_wr_ready;

  assign w_push_entry.addr = r_base + ADDR_W'(r_x);
  assign w_push_entry.data = s_axis.s_axis_tdata;

  axis_skid_fifo2 #(.entry_t(entry_t)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_cnt   (w_fifo_cnt),
    .o_empty (w_fifo_empty)
  );

  assign o_wr_en   = ~w_fifo_empty;
  assign o_wr_addr = w_head.addr;
  assign o_wr_data = w_head.data;
  assign o_busy    = (r_state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_frame_done = 1'b0;
    unique case (r_state)
      IDLE:  if (w_accept) w_next_state = w_eof ? DRAIN : RECV;
      RECV:  if (w_accept && w_eof) w_next_state = DRAIN;
      DRAIN: if (w_fifo_empty) begin
        w_next_state = IDLE;
        o_frame_done = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_err_set = '0;
    if (w_accept) begin
      if (!r_drop && w_eol && (r_x < X_LAST))   w_err_set[ERR_EOL_EARLY]   = 1'b1;
      if (!r_drop && !w_eol && (r_x == X_LAST)) w_err_set[ERR_EOL_MISSING] = 1'b1;
      if (w_eof && !(w_eol && (r_y == Y_LAST))) w_err_set[ERR_EOF]         = 1'b1;
      // Running past the last line without eof is also an eof fault.
      if (!w_eof && w_eol && (r_y == Y_LAST))   w_err_set[ERR_EOF]         = 1'b1;
    end
  end

  // Geometry counters; r_base tracks y*H_OUT so no multiplier is needed.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_base <= '0;
      r_drop <= 1'b0;
    end else if (w_accept) begin
      if (w_eof) begin
        r_x    <= '0;
        r_y    <= '0;
        r_base <= '0;
        r_drop <= 1'b0;
      end else if (w_eol) begin
        r_x    <= '0;
        r_drop <= 1'b0;
        if (r_y == Y_LAST) begin
          r_y    <= '0;
          r_base <= '0;
        end else begin
          r_y    <= r_y + Y_W'(1);
          r_base <= r_base + LINE_STEP;
        end
      end else if (!r_drop) begin
        if (r_x == X_LAST) r_drop <= 1'b1;
        else               r_x    <= r_x + X_W'(1);
      end
    end
  end

  // Set takes priority over a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_err       <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_err <= (i_clr_err ? '0 : r_err) | w_err_set;
      if (o_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt       = r_frame_cnt;
  assign o_err_eol_early   = r_err[ERR_EOL_EARLY];
  assign o_err_eol_missing = r_err[ERR_EOL_MISSING];
  assign o_err_eof         = r_err[ERR_EOF];
endmodule

// File: tb/tb_axis_frame_receiver.sv
// tb/tb_axis_frame_receiver.sv - directed self-checking bench for axis_frame_receiver
module tb_axis_frame_receiver;
  logic        clk = 1'b0;
  logic        rstn, en, wr_ready, clr_err;
  logic        o_wr_en, o_busy, o_frame_done;
  logic [2:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [15:0] o_frame_cnt;
  logic        o_err_eol_early, o_err_eol_missing, o_err_eof;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int done_pulses = 0;
  logic [2:0]  wq_a[$];
  logic [31:0] wq_d[$];

  axis_frame_receiver_if #(.DATA_W(32)) bus ();

  axis_frame_receiver #(.DATA_W(32), .H_OUT(4), .V_OUT(2), .ADDR_W(3)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .s_axis(bus),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_ready(wr_ready), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frame_cnt(o_frame_cnt), .o_err_eol_early(o_err_eol_early),
    .o_err_eol_missing(o_err_eol_missing), .o_err_eof(o_err_eof),
    .i_clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Write-port and frame_done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rstn && o_wr_en && wr_ready) begin
      wq_a.push_back(o_wr_addr);
      wq_d.push_back(o_wr_data);
      last_wr_cyc = cyc;
    end
    if (rstn && o_frame_done) begin
      done_pulses++;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_px(input logic [31:0] d, input logic eol, input logic eof);
    int n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    bus.i_eol = eol;
    bus.i_eof = eof;
    @(negedge clk);
    while (!bus.s_axis_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_axis_tready) begin
      n_total++;
      $display("FAIL send_timeout data=%h tready=%b required 1", d, bus.s_axis_tready);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.i_eol = 1'b0;
    bus.i_eof = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_pulses < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_pulses < target) begin
      n_total++;
      $display("FAIL done_timeout pulses=%0d required %0d", done_pulses, target);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; en = 1'b0; wr_ready = 1'b0; clr_err = 1'b0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.i_eol = 1'b0; bus.i_eof = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (o_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b required 0", o_wr_en); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %b required 0", o_busy); else n_pass++;
    n_total++; if (o_frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt got %0d required 0", o_frame_cnt); else n_pass++;
    n_total++; if ({o_err_eol_early, o_err_eol_missing, o_err_eof, o_frame_done} !== 4'b0)
      $display("FAIL rst_flags got %b required 0000", {o_err_eol_early, o_err_eol_missing, o_err_eof, o_frame_done}); else n_pass++;
    n_total++; if ({o_wr_addr, o_wr_data, bus.s_axis_tready} !== 36'd0)
      $display("FAIL rst_wr_bus got %h/%h/%b required 0", o_wr_addr, o_wr_data, bus.s_axis_tready); else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1; en = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    n_total++; if (bus.s_axis_tready !== 1'b1) $display("FAIL idle_tready got %b required 1", bus.s_axis_tready); else n_pass++;
  endtask

  task automatic test_basic_frame;
    int start = done_pulses;
    wq_a.delete(); wq_d.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_px(32'h100 + i, (i == 3) || (i == 7), i == 7);
    wait_done(start + 1);
    n_total++; if (wq_a.size() != 8) $display("FAIL basic_count got %0d required 8", wq_a.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (wq_a[i] !== 3'(i) || wq_d[i] !== 32'h100 + i)
        $display("FAIL basic_wr%0d got %h/%h required %h/%h", i, wq_a[i], wq_d[i], 3'(i), 32'h100 + i);
      else n_pass++;
    end
    n_total++; if (done_cyc != last_wr_cyc + 1) $display("FAIL basic_done_timing got %0d required %0d", done_cyc, last_wr_cyc + 1); else n_pass++;
    n_total++; if (done_pulses != start + 1) $display("FAIL basic_done_pulses got %0d required %0d", done_pulses, start + 1); else n_pass++;
    n_total++; if (o_frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt got %0d required 1", o_frame_cnt); else n_pass++;
    n_total++; if ({o_err_eol_early, o_err_eol_missing, o_err_eof, o_busy} !== 4'b0)
      $display("FAIL basic_flags got %b required 0000", {o_err_eol_early, o_err_eol_missing, o_err_eof, o_busy}); else n_pass++;
  endtask

  task automatic test_backpressure;
    int start = done_pulses;
    wq_a.delete(); wq_d.delete();
    @(posedge clk); #1;
    wr_ready = 1'b0;
    send_px(32'h100, 1'b0, 1'b0);
    send_px(32'h101, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (bus.s_axis_tready !== 1'b0) $display("FAIL bp_tready got %b required 0", bus.s_axis_tready); else n_pass++;
    n_total++; if (o_wr_en !== 1'b1 || o_wr_addr !== 3'd0 || o_wr_data !== 32'h100)
      $display("FAIL bp_head got %b/%h/%h required 1/0/00000100", o_wr_en, o_wr_addr, o_wr_data); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL bp_busy got %b required 1", o_busy); else n_pass++;
    repeat (3) @(posedge clk);
    #1 wr_ready = 1'b1;
    for (int i = 2; i < 8; i++) send_px(32'h100 + i, (i == 3) || (i == 7), i == 7);
    wait_done(start + 1);
    n_total++; if (wq_a.size() != 8) $display("FAIL bp_count got %0d required 8", wq_a.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (wq_a[i] !== 3'(i) || wq_d[i] !== 32'h100 + i)
        $display("FAIL bp_wr%0d got %h/%h required %h/%h", i, wq_a[i], wq_d[i], 3'(i), 32'h100 + i);
      else n_pass++;
    end
    n_total++; if (o_frame_cnt !== 16'd2) $display("FAIL bp_frame_cnt got %0d required 2", o_frame_cnt); else n_pass++;
  endtask

  task automatic test_eol_early;
    int start = done_pulses;
    logic [2:0] exp_a [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    wq_a.delete(); wq_d.delete();
    @(posedge clk); #1;
    send_px(32'h200, 1'b0, 1'b0);
    send_px(32'h201, 1'b0, 1'b0);
    send_px(32'h202, 1'b1, 1'b0);
    for (int i = 3; i < 7; i++) send_px(32'h200 + i, i == 6, i == 6);
    wait_done(start + 1);
    n_total++; if (wq_a.size() != 7) $display("FAIL early_count got %0d required 7", wq_a.size()); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (wq_a[i] !== exp_a[i] || wq_d[i] !== 32'h200 + i)
        $display("FAIL early_wr%0d got %h/%h required %h/%h", i, wq_a[i], wq_d[i], exp_a[i], 32'h200 + i);
      else n_pass++;
    end
    n_total++; if ({o_err_eol_early, o_err_eol_missing, o_err_eof} !== 3'b100)
      $display("FAIL early_errs got %b required 100", {o_err_eol_early, o_err_eol_missing, o_err_eof}); else n_pass++;
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    n_total++; if (o_err_eol_early !== 1'b0) $display("FAIL early_clear got %b required 0", o_err_eol_early); else n_pass++;
    n_total++; if (o_frame_cnt !== 16'd3) $display("FAIL early_frame_cnt got %0d required 3", o_frame_cnt); else n_pass++;
  endtask

  task automatic test_eol_missing;
    int start = done_pulses;
    logic [31:0] exp_d [8] = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h306, 32'h307, 32'h308, 32'h309};
    wq_a.delete(); wq_d.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send_px(32'h300 + i, i == 5, 1'b0);
    for (int i = 6; i < 10; i++) send_px(32'h300 + i, i == 9, i == 9);
    wait_done(start + 1);
    n_total++; if (wq_a.size() != 8) $display("FAIL miss_count got %0d required 8", wq_a.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (wq_a[i] !== 3'(i) || wq_d[i] !== exp_d[i])
        $display("FAIL miss_wr%0d got %h/%h required %h/%h", i, wq_a[i], wq_d[i], 3'(i), exp_d[i]);
      else n_pass++;
    end
    n_total++; if ({o_err_eol_early, o_err_eol_missing, o_err_eof} !== 3'b010)
      $display("FAIL miss_errs got %b required 010", {o_err_eol_early, o_err_eol_missing, o_err_eof}); else n_pass++;
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    n_total++; if (o_err_eol_missing !== 1'b0) $display("FAIL miss_clear got %b required 0", o_err_eol_missing); else n_pass++;
  endtask

  task automatic test_eof_early;
    int start = done_pulses;
    wq_a.delete(); wq_d.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_px(32'h400 + i, i == 3, i == 3);
    wait_done(start + 1);
    n_total++; if (wq_a.size() != 4) $display("FAIL eof_count got %0d required 4", wq_a.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (wq_a[i] !== 3'(i) || wq_d[i] !== 32'h400 + i)
        $display("FAIL eof_wr%0d got %h/%h required %h/%h", i, wq_a[i], wq_d[i], 3'(i), 32'h400 + i);
      else n_pass++;
    end
    n_total++; if ({o_err_eol_early, o_err_eol_missing, o_err_eof} !== 3'b001)
      $display("FAIL eof_errs got %b required 001", {o_err_eol_early, o_err_eol_missing, o_err_eof}); else n_pass++;
    n_total++; if (o_frame_cnt !== 16'd5 || o_busy !== 1'b0)
      $display("FAIL eof_frame got cnt=%0d busy=%b required cnt=5 busy=0", o_frame_cnt, o_busy); else n_pass++;
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    // Next frame restarts at address 0, with a receive-enable gap mid-line.
    start = done_pulses;
    wq_a.delete(); wq_d.delete();
    send_px(32'h500, 1'b0, 1'b0);
    send_px(32'h501, 1'b0, 1'b0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (bus.s_axis_tready !== 1'b0 || o_busy !== 1'b1 || o_wr_en !== 1'b0)
      $display("FAIL en_hold got tready=%b busy=%b wr_en=%b required 0/1/0", bus.s_axis_tready, o_busy, o_wr_en); else n_pass++;
    @(posedge clk); #1 en = 1'b1;
    for (int i = 2; i < 8; i++) send_px(32'h500 + i, (i == 3) || (i == 7), i == 7);
    wait_done(start + 1);
    n_total++; if (wq_a.size() != 8) $display("FAIL resync_count got %0d required 8", wq_a.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (wq_a[i] !== 3'(i) || wq_d[i] !== 32'h500 + i)
        $display("FAIL resync_wr%0d got %h/%h required %h/%h", i, wq_a[i], wq_d[i], 3'(i), 32'h500 + i);
      else n_pass++;
    end
    n_total++; if (o_err_eof !== 1'b0 || o_frame_cnt !== 16'd6)
      $display("FAIL resync_state got err_eof=%b cnt=%0d required 0/6", o_err_eof, o_frame_cnt); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    int start;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_px(32'h600 + i, 1'b0, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    n_total++; if ({o_wr_en, o_busy, o_frame_done} !== 3'b000)
      $display("FAIL mrst_ctrl got %b required 000", {o_wr_en, o_busy, o_frame_done}); else n_pass++;
    n_total++; if (o_frame_cnt !== 16'd0 || o_wr_addr !== 3'd0 || o_wr_data !== 32'd0)
      $display("FAIL mrst_regs got %0d/%h/%h required 0/0/0", o_frame_cnt, o_wr_addr, o_wr_data); else n_pass++;
    start = done_pulses;
    wq_a.delete(); wq_d.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_px(32'h700 + i, (i == 3) || (i == 7), i == 7);
    wait_done(start + 1);
    n_total++; if (wq_a.size() != 8) $display("FAIL mrst_count got %0d required 8", wq_a.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (wq_a[i] !== 3'(i) || wq_d[i] !== 32'h700 + i)
        $display("FAIL mrst_wr%0d got %h/%h required %h/%h", i, wq_a[i], wq_d[i], 3'(i), 32'h700 + i);
      else n_pass++;
    end
    n_total++; if (o_frame_cnt !== 16'd1 || {o_err_eol_early, o_err_eol_missing, o_err_eof} !== 3'b000)
      $display("FAIL mrst_final got cnt=%0d errs=%b required 1/000", o_frame_cnt, {o_err_eol_early, o_err_eol_missing, o_err_eof}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_eol_early();
    test_eol_missing();
    test_eof_early();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
